// File: rtl/led_ctrl_pkg.sv
// led_ctrl shared definitions: blink codes, LED map, FSM states.
// Imported by the interface, the timer and the top.
package led_ctrl_pkg;

  localparam int NLED = 10;

  typedef enum logic [NLED-1:0] {
    FRE_0P2 = 10'h001,
    FRE_0P5 = 10'h002,
    FRE_1P0 = 10'h004,
    FRE_1P5 = 10'h008,
    FRE_2P0 = 10'h010,
    FRE_2P5 = 10'h020,
    FRE_3P0 = 10'h040,
    FRE_4P0 = 10'h080,
    FRE_5P0 = 10'h100,
    FRE_6P0 = 10'h200
  } fre_e;

  localparam logic [3:0] LED_RUN  = 4'd0;
  localparam logic [3:0] LED_SET0 = 4'd1;
  localparam logic [3:0] LED_ALM  = 4'd7;
  localparam logic [3:0] LED_CHM  = 4'd8;
  localparam logic [3:0] LED_ARM  = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SET   = 2'd1,
    ST_ALARM = 2'd2,
    ST_CHIME = 2'd3
  } state_e;

  typedef struct packed {
    logic [NLED-1:0] valid;
    logic [NLED-1:0] twinkle;
    logic [NLED-1:0] fre;
    logic            active;
  } led_out_t;

  function automatic logic [NLED-1:0] led_bit(
    input logic [3:0] idx
  );
    return 10'd1 << idx;
  endfunction

endpackage

// File: rtl/led_ctrl_if.sv
// Mode-event inputs and per-LED control outputs of led_ctrl.
// master drives events and observes LEDs; slave is the controller.
interface led_ctrl_if;
  import led_ctrl_pkg::*;

  logic            tick_1s;
  logic            mode_set;
  logic [2:0]      set_field;
  logic            alarm_en;
  logic            alarm_hit;
  logic            hour_pulse;
  logic            key_ack;
  logic [NLED-1:0] valid_led;
  logic [NLED-1:0] twinkle_led;
  logic [NLED-1:0] twinkle_fre;
  logic [NLED-1:0] l_data;
  logic            alarm_active;

  modport master (
    output tick_1s, mode_set, set_field,
    output alarm_en, alarm_hit,
    output hour_pulse, key_ack,
    input  valid_led, twinkle_led,
    input  twinkle_fre, l_data,
    input  alarm_active
  );

  modport slave (
    input  tick_1s, mode_set, set_field,
    input  alarm_en, alarm_hit,
    input  hour_pulse, key_ack,
    output valid_led, twinkle_led,
    output twinkle_fre, l_data,
    output alarm_active
  );
endinterface

// File: rtl/led_ctrl_sec_timer.sv
// Seconds counter for the timed ALARM and CHIME states.
// done fires on the tick that completes limit seconds.
module sec_timer
  import led_ctrl_pkg::*;
(
  input  logic       sysclk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic       tick_1s,
  input  logic [7:0] limit,
  output logic       done
);

  logic [7:0] cnt;

  // clear wins so a tick in the entry cycle is not counted
  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && tick_1s) begin
      cnt <= cnt + 8'd1;
    end
  end

  assign done = tick_1s & en &
                (cnt == limit - 8'd1);

endmodule

// File: rtl/led_ctrl.sv
// Mode-event FSM producing per-LED control vectors for led_itf.
// Outputs are registered decodes of the next state.
module led_ctrl
  import led_ctrl_pkg::*;
#(
  parameter int unsigned ALARM_SEC = 60,
  parameter int unsigned CHIME_SEC = 3
) (
  input  logic       sysclk,
  input  logic       rst,
  led_ctrl_if.slave  bus
);

  state_e          state;
  state_e          state_nxt;
  logic            tmr_en;
  logic            tmr_clr;
  logic            tmr_done;
  logic [7:0]      tmr_limit;
  logic            alarm_req;
  logic            alarm_stop;
  logic [NLED-1:0] armed;
  logic [NLED-1:0] field;
  led_out_t        o_nxt;
  led_out_t        o_q;

  assign tmr_en = (state == ST_ALARM) ||
                  (state == ST_CHIME);
  assign tmr_clr = (state_nxt != state);
  assign tmr_limit = (state == ST_ALARM) ?
                     8'(ALARM_SEC) :
                     8'(CHIME_SEC);

  sec_timer u_timer (
    .sysclk  (sysclk),
    .rst     (rst),
    .clr     (tmr_clr),
    .en      (tmr_en),
    .tick_1s (bus.tick_1s),
    .limit   (tmr_limit),
    .done    (tmr_done)
  );

  assign alarm_req = bus.alarm_hit & bus.alarm_en;
  assign alarm_stop = bus.key_ack | ~bus.alarm_en |
                      tmr_done;

  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (alarm_req)           state_nxt = ST_ALARM;
        else if (bus.mode_set)   state_nxt = ST_SET;
        else if (bus.hour_pulse) state_nxt = ST_CHIME;
      end
      ST_SET: begin
        if (alarm_req)         state_nxt = ST_ALARM;
        else if (!bus.mode_set) state_nxt = ST_IDLE;
      end
      ST_ALARM: begin
        if (alarm_stop)
          state_nxt = bus.mode_set ? ST_SET : ST_IDLE;
      end
      ST_CHIME: begin
        if (alarm_req)         state_nxt = ST_ALARM;
        else if (bus.mode_set) state_nxt = ST_SET;
        else if (bus.key_ack || tmr_done)
          state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // fields 6 and 7 mean no field is being edited
  assign field = (bus.set_field < 3'd6) ?
                 led_bit(LED_SET0 + 4'(bus.set_field)) :
                 '0;
  assign armed = bus.alarm_en ? led_bit(LED_ARM) : '0;

  always_comb begin
    o_nxt.valid   = led_bit(LED_RUN) | armed;
    o_nxt.twinkle = '0;
    o_nxt.fre     = FRE_1P0;
    o_nxt.active  = 1'b0;
    unique case (1'b1)
      state_nxt == ST_SET: begin
        o_nxt.valid   = o_nxt.valid | field;
        o_nxt.twinkle = field;
        o_nxt.fre     = FRE_0P5;
      end
      state_nxt == ST_ALARM: begin
        o_nxt.valid   = led_bit(LED_RUN) |
                        led_bit(LED_ALM) |
                        led_bit(LED_ARM);
        o_nxt.twinkle = led_bit(LED_ALM);
        o_nxt.fre     = FRE_0P2;
        o_nxt.active  = 1'b1;
      end
      state_nxt == ST_CHIME: begin
        o_nxt.valid   = o_nxt.valid |
                        led_bit(LED_CHM);
        o_nxt.twinkle = led_bit(LED_CHM);
        o_nxt.fre     = FRE_0P5;
      end
      default: ;
    endcase
  end

  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      o_q.valid   <= led_bit(LED_RUN);
      o_q.twinkle <= '0;
      o_q.fre     <= FRE_1P0;
      o_q.active  <= 1'b0;
    end else begin
      o_q <= o_nxt;
    end
  end

  assign bus.valid_led    = o_q.valid;
  assign bus.l_data       = o_q.valid;
  assign bus.twinkle_led  = o_q.twinkle;
  assign bus.twinkle_fre  = o_q.fre;
  assign bus.alarm_active = o_q.active;

endmodule

// File: tb/tb_led_ctrl.sv
// Directed bench for led_ctrl with an expected-output queue.
// ALARM_SEC = CHIME_SEC = 3.
module tb_led_ctrl;

  logic sysclk = 1'b0;
  logic rst;

  always #10 sysclk = ~sysclk;

  led_ctrl_if bus ();

  led_ctrl #(
    .ALARM_SEC (3),
    .CHIME_SEC (3)
  ) dut (
    .sysclk (sysclk),
    .rst    (rst),
    .bus    (bus)
  );

  typedef struct {
    string      tag;
    logic [9:0] v;
    logic [9:0] tw;
    logic [9:0] fr;
    logic       act;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  function automatic exp_t mk(
    input string tag, input logic [9:0] v,
    input logic [9:0] tw, input logic [9:0] fr,
    input logic act
  );
    exp_t e;
    e.tag = tag; e.v = v; e.tw = tw;
    e.fr = fr; e.act = act;
    return e;
  endfunction

  function automatic logic [9:0] arm(input logic a);
    return a ? 10'h200 : 10'h000;
  endfunction

  function automatic exp_t e_rst(input string t);
    return mk(t, 10'h001, 10'h000, 10'h004, 1'b0);
  endfunction

  function automatic exp_t e_idle(
    input string t, input logic a
  );
    return mk(t, 10'h001 | arm(a), 10'h000,
              10'h004, 1'b0);
  endfunction

  function automatic exp_t e_set(
    input string t, input int f, input logic a
  );
    logic [9:0] fl;
    fl = (f < 6) ? (10'h002 << f) : 10'h000;
    return mk(t, 10'h001 | fl | arm(a), fl,
              10'h002, 1'b0);
  endfunction

  function automatic exp_t e_alarm(input string t);
    return mk(t, 10'h281, 10'h080, 10'h001, 1'b1);
  endfunction

  function automatic exp_t e_chime(
    input string t, input logic a
  );
    return mk(t, 10'h101 | arm(a), 10'h100,
              10'h002, 1'b0);
  endfunction

  task automatic chk(
    input string tag, input string f,
    input logic [9:0] got, input logic [9:0] exp
  );
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s %s got=%h exp=%h",
             tag, f, got, exp);
    end
  endtask

  task automatic check_now();
    exp_t e;
    while (q.size() > 0) begin
      e = q.pop_front();
      chk(e.tag, "valid_led", bus.valid_led, e.v);
      chk(e.tag, "l_data", bus.l_data, e.v);
      chk(e.tag, "twinkle_led", bus.twinkle_led, e.tw);
      chk(e.tag, "twinkle_fre", bus.twinkle_fre, e.fr);
      chk(e.tag, "alarm_active",
          {9'd0, bus.alarm_active}, {9'd0, e.act});
    end
  endtask

  task automatic step(input exp_t e);
    q.push_back(e);
    @(posedge sysclk);
    #1;
    check_now();
    bus.tick_1s    = 1'b0;
    bus.alarm_hit  = 1'b0;
    bus.hour_pulse = 1'b0;
    bus.key_ack    = 1'b0;
  endtask

  initial begin
    rst            = 1'b1;
    bus.tick_1s    = 1'b0;
    bus.mode_set   = 1'b0;
    bus.set_field  = 3'd7;
    bus.alarm_en   = 1'b1;
    bus.alarm_hit  = 1'b0;
    bus.hour_pulse = 1'b0;
    bus.key_ack    = 1'b0;

    step(e_rst("rst_hold"));
    step(e_rst("rst_hold2"));
    rst = 1'b0;
    q.push_back(e_rst("rst_rel"));
    check_now();
    step(e_idle("idle_armed", 1'b1));
    bus.alarm_en = 1'b0;
    step(e_idle("idle_plain", 1'b0));

    bus.mode_set = 1'b1;
    bus.set_field = 3'd3;
    step(e_set("set_f3", 3, 1'b0));
    bus.set_field = 3'd7;
    step(e_set("set_f7", 7, 1'b0));
    bus.set_field = 3'd5;
    step(e_set("set_f5", 5, 1'b0));
    bus.hour_pulse = 1'b1;
    step(e_set("set_hour", 5, 1'b0));
    bus.mode_set = 1'b0;
    step(e_idle("set_exit", 1'b0));
    step(e_idle("no_queued_chime", 1'b0));
    bus.alarm_en = 1'b1;
    bus.mode_set = 1'b1;
    bus.set_field = 3'd0;
    step(e_set("set_f0_arm", 0, 1'b1));
    bus.mode_set = 1'b0;
    step(e_idle("set_exit2", 1'b1));

    bus.alarm_hit = 1'b1;
    step(e_alarm("alm_enter"));
    bus.tick_1s = 1'b1;
    step(e_alarm("alm_t1"));
    bus.alarm_hit = 1'b1;
    step(e_alarm("alm_rehit"));
    bus.tick_1s = 1'b1;
    step(e_alarm("alm_t2"));
    step(e_alarm("alm_gap"));
    bus.tick_1s = 1'b1;
    step(e_idle("alm_timeout", 1'b1));

    bus.alarm_hit = 1'b1;
    bus.hour_pulse = 1'b1;
    bus.tick_1s = 1'b1;
    step(e_alarm("coll_enter"));
    bus.tick_1s = 1'b1;
    step(e_alarm("coll_t1"));
    bus.tick_1s = 1'b1;
    step(e_alarm("coll_t2"));
    bus.tick_1s = 1'b1;
    step(e_idle("coll_exit", 1'b1));
    step(e_idle("coll_no_chime", 1'b1));

    bus.alarm_hit = 1'b1;
    step(e_alarm("ack_enter"));
    bus.mode_set = 1'b1;
    bus.set_field = 3'd2;
    bus.key_ack = 1'b1;
    step(e_set("ack_to_set", 2, 1'b1));
    bus.mode_set = 1'b0;
    step(e_idle("ack_set_exit", 1'b1));

    bus.alarm_hit = 1'b1;
    step(e_alarm("endrop_enter"));
    bus.alarm_en = 1'b0;
    step(e_idle("endrop_exit", 1'b0));

    bus.hour_pulse = 1'b1;
    step(e_chime("chm_enter", 1'b0));
    bus.tick_1s = 1'b1;
    step(e_chime("chm_t1", 1'b0));
    step(e_chime("chm_gap", 1'b0));
    bus.tick_1s = 1'b1;
    step(e_chime("chm_t2", 1'b0));
    bus.tick_1s = 1'b1;
    step(e_idle("chm_done", 1'b0));

    bus.hour_pulse = 1'b1;
    step(e_chime("chm2_enter", 1'b0));
    bus.key_ack = 1'b1;
    step(e_idle("chm_ack", 1'b0));

    bus.hour_pulse = 1'b1;
    step(e_chime("chm3_enter", 1'b0));
    bus.mode_set = 1'b1;
    bus.set_field = 3'd6;
    step(e_set("chm_abort", 6, 1'b0));
    bus.mode_set = 1'b0;
    step(e_idle("chm_abort_exit", 1'b0));

    bus.alarm_en = 1'b1;
    bus.hour_pulse = 1'b1;
    step(e_chime("chm_arm", 1'b1));
    bus.alarm_hit = 1'b1;
    step(e_alarm("chm_preempt"));
    bus.key_ack = 1'b1;
    step(e_idle("preempt_ack", 1'b1));

    bus.alarm_hit = 1'b1;
    step(e_alarm("rst_mid_enter"));
    #3;
    rst = 1'b1;
    #1;
    q.push_back(e_rst("rst_async"));
    check_now();
    step(e_rst("rst_mid_hold"));
    rst = 1'b0;
    step(e_idle("rst_mid_rel", 1'b1));

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
